fp16_to_fixed_converter: RTL

- Decodes IEEE-754 half-precision words (sign, 5-bit exponent with bias 15, 10-bit fraction) into signed two's-complement fixed-point.
- Inverse-direction companion to the FP16 arithmetic units: it unpacks FP16 results so fixed-point consumers (softmax/scaling logic) can use them.
- Two-stage pipeline with valid/ready on both sides; sustains one conversion per cycle when not back-pressured.

---
 rtl/fp16_to_fixed_converter_if.sv | 34 +++
 rtl/fp16_to_fixed_converter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/fp16_to_fixed_converter_if.sv
// ---------------------------------------------------------------------------
// fp16_to_fixed_converter_if
// Handshake bundle for the FP16 -> fixed-point converter.
//   in_valid  : producer has an FP16 word on in_data
//   in_ready  : converter accepts in_data this cycle
//   in_data   : FP16 operand (sign, 5-bit exponent, 10-bit fraction)
//   out_valid : out_data/out_flags carry a result
//   out_ready : consumer accepts the result this cycle
//   out_data  : signed fixed-point result, OUT_W bits
//   out_flags : {nan_inf, sat, uflow}
// Modports: master = producer/consumer side, slave = converter side.
// OUT_W must match the converter's OUT_W parameter.
// ---------------------------------------------------------------------------
interface fp16_to_fixed_converter_if #(
   parameter int OUT_W = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [15:0]      in_data;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_data;
   logic [2:0]       out_flags;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_flags
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_flags
   );
endinterface

// File: rtl/fp16_to_fixed_converter.sv
// ---------------------------------------------------------------------------
// fp16_to_fixed_converter
// Converts IEEE-754 half-precision words into signed two's-complement
// fixed point with FRAC_W fractional bits, in a two-stage pipeline:
//   stage 1 : unpack and shift the mantissa into place
//   stage 2 : optional rounding, saturation, sign application, flags
// Ports:
//   clk : clock, rising edge
//   rst : synchronous, active-low reset
//   bus : fp16_to_fixed_converter_if.slave (valid/ready in and out)
// Optional build macro FP2FX_ROUND_EN: round half away from zero on the
// magnitude using the first discarded bit; undefined = truncate toward 0.
// ---------------------------------------------------------------------------
module fp16_to_fixed_converter #(
   parameter int OUT_W  = 32,
   parameter int FRAC_W = 16
) (
   input logic                      clk,
   input logic                      rst,
   fp16_to_fixed_converter_if.slave bus
);
   // Wide enough that the largest left shift never wraps.
   localparam int MAG_W = OUT_W + 12;

   localparam logic [MAG_W-1:0] POS_LIM = (MAG_W'(1) << (OUT_W - 1)) - MAG_W'(1);
   localparam logic [MAG_W-1:0] NEG_LIM = MAG_W'(1) << (OUT_W - 1);
   localparam logic [OUT_W-1:0] MAX_POS = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0] MIN_NEG = {1'b1, {(OUT_W-1){1'b0}}};

   localparam logic [2:0] FLAG_NAN_INF = 3'b100;
   localparam logic [2:0] FLAG_SAT     = 3'b010;
   localparam logic [2:0] FLAG_UFLOW   = 3'b001;

   // Single enable for both stages: bubbles travel with the data.
   logic en;
   assign en           = ~bus.out_valid | bus.out_ready;
   assign bus.in_ready = en;

   // ---------------- stage 1: unpack / shift ----------------
   logic             s1_valid_q;
   logic             s1_sign_q,    s1_sign_d;
   logic [MAG_W-1:0] s1_mag_q,     s1_mag_d;
   logic             s1_nan_inf_q, s1_nan_inf_d;
   logic             s1_zero_q,    s1_zero_d;
   logic             s1_sub_q,     s1_sub_d;
   logic             s1_guard_q,   s1_guard_d;

   logic [4:0]       exp_w;
   logic [9:0]       frac_w;
   logic [MAG_W-1:0] mant_ext;
   int               sh;
`ifdef FP2FX_ROUND_EN
   logic [MAG_W-1:0] guard_vec;
`endif

   always_comb begin
      s1_sign_d    = bus.in_data[15];
      exp_w        = bus.in_data[14:10];
      frac_w       = bus.in_data[9:0];
      mant_ext     = {{(MAG_W-11){1'b0}}, 1'b1, frac_w};
      sh           = int'(exp_w) - 25 + FRAC_W;
      s1_nan_inf_d = (exp_w == 5'd31);
      s1_zero_d    = (exp_w == 5'd0);
      s1_sub_d     = (exp_w == 5'd0) && (frac_w != 10'd0);
      if (sh >= 0) begin
         s1_mag_d = mant_ext << sh;
      end else begin
         s1_mag_d = mant_ext >> (-sh);
      end
      s1_guard_d = 1'b0;
`ifdef FP2FX_ROUND_EN
      // Guard is the most significant bit dropped by the right shift.
      guard_vec = '0;
      if (sh < 0) begin
         guard_vec  = mant_ext >> (-sh - 1);
         s1_guard_d = guard_vec[0];
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         s1_valid_q   <= 1'b0;
         s1_sign_q    <= 1'b0;
         s1_mag_q     <= '0;
         s1_nan_inf_q <= 1'b0;
         s1_zero_q    <= 1'b0;
         s1_sub_q     <= 1'b0;
         s1_guard_q   <= 1'b0;
      end else if (en) begin
         s1_valid_q   <= bus.in_valid;
         s1_sign_q    <= s1_sign_d;
         s1_mag_q     <= s1_mag_d;
         s1_nan_inf_q <= s1_nan_inf_d;
         s1_zero_q    <= s1_zero_d;
         s1_sub_q     <= s1_sub_d;
         s1_guard_q   <= s1_guard_d;
      end
   end

   // ---------------- stage 2: round / saturate / sign ----------------
   logic             out_valid_q;
   logic [OUT_W-1:0] out_data_q,  out_data_d;
   logic [2:0]       out_flags_q, out_flags_d;
   logic [MAG_W-1:0] rmag;

   always_comb begin
`ifdef FP2FX_ROUND_EN
      rmag = s1_mag_q + {{(MAG_W-1){1'b0}}, s1_guard_q};
`else
      rmag = s1_mag_q;
`endif
      out_data_d  = '0;
      out_flags_d = '0;
      // Priority order gives mutually exclusive flags: nan_inf > sat > uflow.
      if (s1_nan_inf_q) begin
         out_data_d  = s1_sign_q ? MIN_NEG : MAX_POS;
         out_flags_d = FLAG_NAN_INF;
      end else if (s1_zero_q) begin
         out_flags_d = s1_sub_q ? FLAG_UFLOW : 3'b000;
      end else if (!s1_sign_q && (rmag > POS_LIM)) begin
         out_data_d  = MAX_POS;
         out_flags_d = FLAG_SAT;
      end else if (s1_sign_q && (rmag > NEG_LIM)) begin
         out_data_d  = MIN_NEG;
         out_flags_d = FLAG_SAT;
      end else if (rmag == '0) begin
         out_flags_d = FLAG_UFLOW;
      end else begin
         // Magnitude exactly 2^(OUT_W-1) with s=1 negates to MIN_NEG.
         out_data_d = s1_sign_q ? (OUT_W'(0) - rmag[OUT_W-1:0]) : rmag[OUT_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_flags_q <= '0;
      end else if (en) begin
         out_valid_q <= s1_valid_q;
         // Keep the last result visible across bubbles.
         if (s1_valid_q) begin
            out_data_q  <= out_data_d;
            out_flags_q <= out_flags_d;
         end
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_flags = out_flags_q;

endmodule
